// File: rtl/rv_core_pkg.sv
// Shared RV32 core types: ALU opcodes, ID/EX state enum, widths.
// Imported by the ID/EX stage and its forwarding mux.
package rv_core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLTU = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } idex_state_e;

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand forwarding mux: EX/MEM beats MEM/WB beats the stored value.
// x0 never forwards, and a source must be writing to be used.
module fwd_mux
  import rv_core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic [RA_W-1:0] rs,
  input  logic [XLEN-1:0] rs_data,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_regwrite,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  logic exm_hit;
  logic wb_hit;

  // Qualify each producer, then pick the youngest match.
  always_comb begin
    exm_hit = exm_regwrite && (exm_rd != '0)
              && (exm_rd == rs);
    wb_hit  = wb_regwrite && (wb_rd != '0)
              && (wb_rd == rs);
    fwd_data = rs_data;
    if (exm_hit) begin
      fwd_data = exm_result;
    end else if (wb_hit) begin
      fwd_data = wb_result;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwarding, load-use bubble, handshakes.
// Optional IDEX_STALL_CNT_EN adds a saturating stall-cycle counter.
module id_ex_stage
  import rv_core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [3:0]      id_alusel,
  input  logic            id_asrc,
  input  logic            id_bsrc,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic [RA_W-1:0] exm_rd,
  input  logic            exm_regwrite,
  input  logic [XLEN-1:0] exm_result,
  input  logic [RA_W-1:0] wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALUsel,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite
`ifdef IDEX_STALL_CNT_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);

  idex_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [RA_W-1:0] rs1_q, rs1_d;
  logic [RA_W-1:0] rs2_q, rs2_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [3:0]      alusel_q, alusel_d;
  logic            asrc_q, asrc_d;
  logic            bsrc_q, bsrc_d;
  logic            regwrite_q, regwrite_d;
  logic            memread_q, memread_d;
  logic            memwrite_q, memwrite_d;

  logic            full;
  logic            hazard;
  logic            up_xfer;
  logic            stall;
  logic            rs1_hit;
  logic            rs2_hit;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .rs           (rs1_q),
    .rs_data      (rs1_data_q),
    .exm_rd       (exm_rd),
    .exm_regwrite (exm_regwrite),
    .exm_result   (exm_result),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_result    (wb_result),
    .fwd_data     (rs1_fwd)
  );

  fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .rs           (rs2_q),
    .rs_data      (rs2_data_q),
    .exm_rd       (exm_rd),
    .exm_regwrite (exm_regwrite),
    .exm_result   (exm_result),
    .wb_rd        (wb_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_result    (wb_result),
    .fwd_data     (rs2_fwd)
  );

  // Load-use detection and upstream handshake.
  always_comb begin
    full    = (state_q == FULL);
    rs1_hit = (rd_q == id_rs1) && !id_asrc;
    rs2_hit = (rd_q == id_rs2)
              && (!id_bsrc || id_memwrite);
    hazard  = full && memread_q && (rd_q != '0)
              && id_valid && (rs1_hit || rs2_hit);
    stall   = full && !ex_ready;
    id_ready = !flush && !hazard
               && (!full || ex_ready);
    up_xfer = id_valid && id_ready;
  end

  // Next-state: flush, capture, drain, or hold with refresh.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    alusel_d   = alusel_q;
    asrc_d     = asrc_q;
    bsrc_d     = bsrc_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    memwrite_d = memwrite_q;
    if (flush) begin
      state_d = EMPTY;
    end else if (up_xfer) begin
      state_d    = FULL;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_d      = id_rs1;
      rs2_d      = id_rs2;
      rd_d       = id_rd;
      alusel_d   = id_alusel;
      asrc_d     = id_asrc;
      bsrc_d     = id_bsrc;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
      memwrite_d = id_memwrite;
    end else if (full && ex_ready) begin
      state_d = EMPTY;
    end else if (stall) begin
      rs1_data_d = rs1_fwd;
      rs2_data_d = rs2_fwd;
    end
  end

  // Pipeline register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      alusel_q   <= '0;
      asrc_q     <= 1'b0;
      bsrc_q     <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      alusel_q   <= alusel_d;
      asrc_q     <= asrc_d;
      bsrc_q     <= bsrc_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
    end
  end

  // Operand selection toward the ALU.
  always_comb begin
    ex_valid      = full;
    A             = asrc_q ? pc_q : rs1_fwd;
    B             = bsrc_q ? imm_q : rs2_fwd;
    ALUsel        = alusel_q;
    ex_store_data = rs2_fwd;
    ex_rd         = rd_q;
    ex_regwrite   = regwrite_q;
    ex_memread    = memread_q;
    ex_memwrite   = memwrite_q;
  end

`ifdef IDEX_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of bubble or back-pressure cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((hazard || stall) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter survives flush; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register of the RV32 core. It sits directly upstream of the ALU and produces its A, B and ALUsel inputs.
- Registers decoded operands and control, resolves EX/MEM and MEM/WB forwarding, and selects PC or immediate operands.
- Detects load-use hazards and inserts a bubble.
- Applies valid/ready handshakes toward decode and toward execute/memory.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  kill the held and incoming instruction (branch redirect).
- id_valid  in  1  decode presents an instruction.
- id_ready  out  1  stage accepts this cycle.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data, id_rs2_data  in  XLEN each  register file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  RA_W each  register addresses.
- id_alusel  in  4  ALU opcode.
- id_asrc  in  1  1: A = PC, 0: A = rs1.
- id_bsrc  in  1  1: B = imm, 0: B = rs2.
- id_regwrite, id_memread, id_memwrite  in  1 each  control bits.
- exm_rd  in  RA_W  EX/MEM destination.
- exm_regwrite  in  1  EX/MEM write enable.
- exm_result  in  XLEN  EX/MEM result.
- wb_rd  in  RA_W  MEM/WB destination.
- wb_regwrite  in  1  MEM/WB write enable.
- wb_result  in  XLEN  MEM/WB result.
- ex_valid  out  1  instruction held for execute.
- ex_ready  in  1  downstream accepts.
- A, B  out  XLEN  ALU operands.
- ALUsel  out  4  ALU opcode.
- ex_store_data  out  XLEN  forwarded rs2 for stores.
- ex_rd  out  RA_W  registered destination.
- ex_regwrite, ex_memread, ex_memwrite  out  1 each  registered control.

Behaviour:
- Reset, asynchronous: state EMPTY, ex_valid=0, all registered fields 0. This gives A=B=0, ALUsel=0, ex_store_data=0, ex_rd=0, and all control outputs 0.
- FSM states:
  - EMPTY (ex_valid=0).
  - FULL (ex_valid=1).
- Downstream transfer: ex_valid & ex_ready. Upstream transfer: id_valid & id_ready.
- hazard = ex_valid & ex_memread & ex_rd!=0 & id_valid & ((ex_rd==id_rs1 & !id_asrc) | (ex_rd==id_rs2 & (!id_bsrc | id_memwrite))).
- id_ready = !flush & !hazard & (state==EMPTY | ex_ready).
- Transitions:
  - flush → EMPTY, regardless of handshakes; the incoming instruction is discarded.
  - Upstream transfer → FULL; capture all id_* fields.
  - FULL & ex_ready & no upstream transfer → EMPTY. This includes a hazard bubble; the bubble lasts exactly one cycle.
  - FULL & !ex_ready → hold.
- Forwarding, combinational per operand:
  - Source priority: EX/MEM over MEM/WB over the stored value.
  - A source forwards only if its regwrite=1, its rd!=0 and its rd equals the stored rs.
- A = PC if asrc, else forwarded rs1.
- B = imm if bsrc, else forwarded rs2.
- ex_store_data = forwarded rs2.
- ALUsel = stored id_alusel.
- Operand refresh: while FULL & !ex_ready, stored rs1/rs2 data are overwritten each cycle with the forwarded values. A producer retiring during a stall is therefore not lost.
- Load-use release: no explicit counter. The hazard clears once the load leaves the stage, and the consumer then forwards from MEM/WB.
- Simultaneous events:
  - Transfer-out and transfer-in in the same cycle stays FULL with the new contents; zero-bubble throughput.
  - flush overrides hazard and operand refresh.
- When EMPTY, outputs reflect the stale registered fields; consumers must qualify with ex_valid.
- Reset mid-operation returns to EMPTY immediately (asynchronous).

Optional Feature:
- Macro: IDEX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (32 bits): saturating count of cycles with hazard=1 or (FULL & !ex_ready).
  - Reset to 0; flush does not clear it.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package rv_core_pkg:
  - ALUsel constants: ADD=0000, SLL=0001, SLTU=0010, SLT=0011, XOR=0100, SRL=0101, OR=0110, AND=0111, SUB=1000, SRA=1101.
  - FSM state enum {EMPTY, FULL}.
  - XLEN/RA_W defaults.
- One sub-module fwd_mux, instantiated twice (rs1, rs2):
  - Inputs: stored rs address and data, EX/MEM and MEM/WB triplets.
  - Output: forwarded data.

Test Plan:
- Reset then single ADD (rs1 data=5, rs2 data=7, asrc=bsrc=0, ex_ready=1):
  - Before the instruction: ex_valid=0, A=B=0.
  - One cycle after acceptance: ex_valid=1, A=5, B=7, ALUsel=0000.
- Forwarding priority, with stored rs1=x3:
  - exm_rd=3, exm_result=0xAA, wb_rd=3, wb_result=0xBB, both regwrite=1: A=0xAA.
  - exm_regwrite=0: A=0xBB.
  - rd=0 on both sources: A equals stored data.
- Load-use:
  - Setup: FULL load to x4 (memread=1); decode presents rs1=x4.
  - Response: id_ready=0 for 1 cycle, ex_valid=0 for one cycle (bubble).
  - Next cycle: the consumer is accepted, wb_result=0x1234 forwards to A.
- Stall refresh:
  - Setup: FULL with rs2=x6, ex_ready=0 for 3 cycles; wb_rd=6, wb_result=0x55 during cycle 1 only.
  - Response: B=0x55 through all cycles until ex_ready=1; id_ready=0 throughout.
- Flush:
  - Stimulus: flush=1 with id_valid=1 and FULL.
  - Response: next cycle ex_valid=0; the incoming instruction never appears.
  - Reset asserted mid-stall: ex_valid=0 asynchronously.
- Back-to-back stream of 8 independent instructions with ex_ready=1:
  - One accepted per cycle, no bubbles.
  - With IDEX_STALL_CNT_EN defined, stall_cnt=0.
